maxpool_s2: RTL and testbench
=============================

MAXPOOL_S2 -- requirements
Module: maxpool_s2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the IEEE-754 single-precision word width.
REQ-002 Parameter IFM_SIZE, default 28, is the input map edge length; it SHALL be even.
REQ-003 Parameter NUMBER_OF_MAPS, default 6, is the number of maps per frame.
REQ-004 Parameter ADDRESS_SIZE_OUT, default $clog2((IFM_SIZE/2)*(IFM_SIZE/2)), is the output address width.
REQ-005 clk  input  1  is the single clock; all logic is rising-edge.
REQ-006 reset  input  1  is the asynchronous, active-low reset.
REQ-007 start  input  1  is a one-cycle pulse that begins a frame.
REQ-008 in_valid  input  1  marks in_data valid; there is no backpressure.
REQ-009 in_data  input  DATA_WIDTH  is the convolution/ReLU output, raster order, map after map.
REQ-010 out_valid  output  1  marks out_data valid for exactly one cycle.
REQ-011 out_data  output  DATA_WIDTH  is the 2x2 maximum.
REQ-012 busy  output  1  is high in RUN.
REQ-013 frame_done  output  1  is a one-cycle pulse after the last output of the last map.
REQ-014 out_address  output  ADDRESS_SIZE_OUT  is the next-layer IFM write address (only under POOL_ADDR_OUT_EN).
REQ-015 out_map_sel  output  $clog2(NUMBER_OF_MAPS)  is the next-layer IFM select (only under POOL_ADDR_OUT_EN).

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when the last input of map NUMBER_OF_MAPS-1 is accepted; DONE->IDLE unconditionally after one cycle.
REQ-017 in_valid SHALL be ignored outside RUN, and start SHALL be ignored outside IDLE.
REQ-018 Column, row and map counters SHALL advance only on an accepted input (RUN and in_valid).
- Column wraps IFM_SIZE-1 -> 0 and increments row.
- Row wraps IFM_SIZE-1 -> 0 and increments map.
- Map wraps NUMBER_OF_MAPS-1 -> 0.
REQ-019 On an even column, in_data SHALL be latched into the horizontal holding register.
REQ-020 On an odd column, hmax = max(holding register, in_data) SHALL be formed.
REQ-021 On an even row, hmax SHALL be written to line buffer entry col/2; the line buffer has IFM_SIZE/2 entries.
REQ-022 On an odd row, max(line buffer[col/2], hmax) SHALL be registered to out_data, with out_valid high on the next cycle (latency 1).
REQ-023 max SHALL follow FP ordering on bit patterns:
- Differing signs: the sign-0 operand wins.
- Both positive: the larger magnitude wins.
- Both negative: the smaller magnitude wins.
- Equal values, including +0 vs -0: the first (earlier) operand wins.
- NaN is not special-cased.
REQ-024 When input gaps occur (in_valid low), state SHALL hold and out_valid SHALL be 0.
REQ-025 frame_done SHALL assert in DONE, which coincides with the cycle out_valid is high for the final output.
REQ-026 Each map SHALL yield exactly (IFM_SIZE/2)^2 out_valid pulses.

Reset
REQ-027 Reset low SHALL immediately force IDLE, zero all counters and holding registers, and drive out_valid=0, out_data=0, busy=0, frame_done=0, out_address=0, out_map_sel=0.
REQ-028 Line buffer contents need not be reset, since they are always written before being read.
REQ-029 A reset mid-frame SHALL abandon the frame; a subsequent start SHALL restart from map 0, row 0, col 0.

Configuration
REQ-030 With POOL_ADDR_OUT_EN defined, out_address and out_map_sel SHALL exist.
- They are registered alongside out_data.
- out_address counts 0..(IFM_SIZE/2)^2-1 per map and resets to 0 at each map boundary.
- out_map_sel equals the map index.
REQ-031 Without POOL_ADDR_OUT_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package SHALL hold DATA_WIDTH, the FSM state enum, and the FP sign/magnitude field widths.
REQ-033 The FP maximum SHALL be one combinational sub-module, fp_max2, instantiated twice (horizontal and vertical).

Verification
REQ-034 Ramp test: with in_data = float(r*28+c) for map 0, the first output SHALL be 29.0 (0x41E80000), the output at (r,c) SHALL be float(56r+2c+29), and the last output SHALL be 783.0 (0x4443C000).
REQ-035 Negative window: inputs -1.0, -2.0 on row 0 and -3.0, -4.0 on row 1 SHALL produce -1.0 (0xBF800000); a window of 0x80000000, 0x00000000, 0x80000000, 0x80000000 SHALL produce 0x80000000.
REQ-036 Full frame: 6x784 inputs with random in_valid gaps SHALL produce exactly 1176 out_valid pulses, one frame_done pulse, and busy low afterwards.
REQ-037 Reset mid-map: assert reset at map 2, row 13, then start again; outputs SHALL resume from map 0 with correct values and no stale out_valid.
REQ-038 With POOL_ADDR_OUT_EN defined, out_address SHALL sequence 0..195 per map and out_map_sel 0..5; start and in_valid asserted in IDLE SHALL produce no outputs.

Source files
------------

// File: rtl/maxpool_s2_pkg.sv
// Shared constants and types for the 2x2 stride-2 floating-point max-pool block.
package maxpool_s2_pkg;

  localparam int unsigned SIGN_W = 1;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;

  localparam int unsigned DATA_WIDTH = SIGN_W + EXP_W + MANT_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fp_max2.sv
// Combinational maximum of two IEEE-754 words, compared on raw sign/magnitude bit patterns.
// On equal values (including +0 vs -0) the earlier operand a_i is returned.
module fp_max2
  import maxpool_s2_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] max_o
);

  localparam int unsigned MagW = Width - SIGN_W;

  logic            a_sign;
  logic            b_sign;
  logic [MagW-1:0] a_mag;
  logic [MagW-1:0] b_mag;
  logic            b_wins;

  assign a_sign = a_i[Width-1];
  assign b_sign = b_i[Width-1];
  assign a_mag  = a_i[MagW-1:0];
  assign b_mag  = b_i[MagW-1:0];

  always_comb begin
    b_wins = 1'b0;
    if (a_sign != b_sign) begin
      // Opposite signs only tie when both operands are zeros.
      b_wins = !b_sign && ((a_mag | b_mag) != '0);
    end else if (!a_sign) begin
      b_wins = b_mag > a_mag;
    end else begin
      b_wins = b_mag < a_mag;
    end
    max_o = b_wins ? b_i : a_i;
  end

endmodule

// File: rtl/maxpool_s2.sv
// 2x2 stride-2 max-pool over raster-ordered FP32 feature maps, one output per 2x2 window.
// Define POOL_ADDR_OUT_EN to add the next-layer write address and map select outputs.
module maxpool_s2 #(
  parameter int unsigned DATA_WIDTH       = maxpool_s2_pkg::DATA_WIDTH,
  parameter int unsigned IFM_SIZE         = 28,
  parameter int unsigned NUMBER_OF_MAPS   = 6,
  parameter int unsigned ADDRESS_SIZE_OUT = $clog2((IFM_SIZE / 2) * (IFM_SIZE / 2))
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                busy,
  output logic                                frame_done
`ifdef POOL_ADDR_OUT_EN
  ,
  output logic [ADDRESS_SIZE_OUT-1:0]         out_address,
  output logic [$clog2(NUMBER_OF_MAPS)-1:0]   out_map_sel
`endif
);

  import maxpool_s2_pkg::*;

  localparam int unsigned Half = IFM_SIZE / 2;
  localparam int unsigned ColW = $clog2(IFM_SIZE);
  localparam int unsigned IdxW = ColW - 1;
  localparam int unsigned MapW = (NUMBER_OF_MAPS > 1) ? $clog2(NUMBER_OF_MAPS) : 1;

  localparam logic [ColW-1:0] EdgeLast = ColW'(IFM_SIZE - 1);
  localparam logic [MapW-1:0] MapLast  = MapW'(NUMBER_OF_MAPS - 1);

  state_e state_q, state_d;

  logic [ColW-1:0]       col_q, col_d;
  logic [ColW-1:0]       row_q, row_d;
  logic [MapW-1:0]       map_q, map_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] lbuf_q [Half];

  logic                  accept;
  logic                  col_odd;
  logic                  row_odd;
  logic                  col_last;
  logic                  row_last;
  logic                  map_last;
  logic                  last_in;
  logic [IdxW-1:0]       lb_idx;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] vmax;

  assign accept   = (state_q == StRun) && in_valid;
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign col_last = (col_q == EdgeLast);
  assign row_last = (row_q == EdgeLast);
  assign map_last = (map_q == MapLast);
  assign last_in  = accept && col_last && row_last && map_last;
  assign lb_idx   = col_q[ColW-1:1];

  // Horizontal pair: earlier pixel is the held even-column value.
  fp_max2 #(
    .Width (DATA_WIDTH)
  ) u_hmax (
    .a_i   (hold_q),
    .b_i   (in_data),
    .max_o (hmax)
  );

  // Vertical pair: earlier row is the buffered even-row result.
  fp_max2 #(
    .Width (DATA_WIDTH)
  ) u_vmax (
    .a_i   (lbuf_q[lb_idx]),
    .b_i   (hmax),
    .max_o (vmax)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_in) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    map_d = map_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          map_d = map_last ? '0 : map_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    hold_d      = hold_q;
    out_valid_d = accept && col_odd && row_odd;
    out_data_d  = out_data_q;
    if (accept && !col_odd) begin
      hold_d = in_data;
    end
    if (out_valid_d) begin
      out_data_d = vmax;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      map_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      map_q       <= map_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      lbuf_q[lb_idx] <= hmax;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q == StRun);
  assign frame_done = (state_q == StDone);

`ifdef POOL_ADDR_OUT_EN
  localparam logic [ADDRESS_SIZE_OUT-1:0] AddrLast = ADDRESS_SIZE_OUT'(Half * Half - 1);

  logic [ADDRESS_SIZE_OUT-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDRESS_SIZE_OUT-1:0] out_address_q, out_address_d;
  logic [MapW-1:0]             out_map_sel_q, out_map_sel_d;

  // The window counter wraps exactly at each map boundary.
  always_comb begin
    addr_cnt_d    = addr_cnt_q;
    out_address_d = out_address_q;
    out_map_sel_d = out_map_sel_q;
    if (out_valid_d) begin
      out_address_d = addr_cnt_q;
      out_map_sel_d = map_q;
      addr_cnt_d    = (addr_cnt_q == AddrLast) ? '0 : addr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt_q    <= '0;
      out_address_q <= '0;
      out_map_sel_q <= '0;
    end else begin
      addr_cnt_q    <= addr_cnt_d;
      out_address_q <= out_address_d;
      out_map_sel_q <= out_map_sel_d;
    end
  end

  assign out_address = out_address_q;
  assign out_map_sel = out_map_sel_q;
`endif

endmodule

// File: tb/tb_maxpool_s2.sv
// Randomized self-checking bench for maxpool_s2 against a value-ordered reference model.
module tb_maxpool_s2;

  localparam int unsigned DW       = 32;
  localparam int unsigned IFM      = 28;
  localparam int unsigned NM       = 6;
  localparam int unsigned HALF     = IFM / 2;
  localparam int unsigned PER_MAP  = IFM * IFM;
  localparam int unsigned NIN      = NM * PER_MAP;
  localparam int unsigned NOUT     = NM * HALF * HALF;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          frame_done;
`ifdef POOL_ADDR_OUT_EN
  localparam int unsigned AW = $clog2(HALF * HALF);
  localparam int unsigned MW = $clog2(NM);
  logic [AW-1:0] out_address;
  logic [MW-1:0] out_map_sel;
  int            exp_addr[$];
  int            exp_map[$];
  int            got_addr[$];
  int            got_map[$];
`endif

  int            n_total = 0;
  int            n_bad   = 0;
  logic [DW-1:0] frame   [NIN];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt = 0;
  logic          done_with_valid = 1'b1;

  maxpool_s2 #(
    .DATA_WIDTH     (DW),
    .IFM_SIZE       (IFM),
    .NUMBER_OF_MAPS (NM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef POOL_ADDR_OUT_EN
    ,
    .out_address (out_address),
    .out_map_sel (out_map_sel)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      got_data.push_back(out_data);
`ifdef POOL_ADDR_OUT_EN
      got_addr.push_back(int'(out_address));
      got_map.push_back(int'(out_map_sel));
`endif
    end
    if (frame_done) begin
      done_cnt++;
      if (!out_valid) done_with_valid = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Map each float onto a signed integer that increases with its real value (+0 == -0).
  function automatic longint fkey(input logic [31:0] v);
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  function automatic logic [31:0] int2f(input int unsigned n);
    int unsigned e;
    if (n == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (n[i]) e = i;
    return {1'b0, 8'(127 + e), 23'(n << (23 - e))};
  endfunction

  // Non-NaN values, with frequent exact ties and signed zeros.
  function automatic logic [31:0] rand_f();
    int unsigned k;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h3F80_0000;
      3:       return 32'hBF80_0000;
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (got_data.size() > i) ? got_data[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NIN; i++) frame[i] = rand_f();
  endtask

  task automatic build_expected();
    exp_data.delete();
`ifdef POOL_ADDR_OUT_EN
    exp_addr.delete();
    exp_map.delete();
`endif
    for (int m = 0; m < NM; m++) begin
      for (int r = 1; r < IFM; r += 2) begin
        for (int c = 1; c < IFM; c += 2) begin
          int          b;
          logic [31:0] top;
          logic [31:0] bot;
          b   = m * PER_MAP;
          top = fmax(frame[b + (r - 1) * IFM + c - 1], frame[b + (r - 1) * IFM + c]);
          bot = fmax(frame[b + r * IFM + c - 1], frame[b + r * IFM + c]);
          exp_data.push_back(fmax(top, bot));
`ifdef POOL_ADDR_OUT_EN
          exp_addr.push_back((r / 2) * HALF + c / 2);
          exp_map.push_back(m);
`endif
        end
      end
    end
  endtask

  task automatic clear_got();
    got_data.delete();
`ifdef POOL_ADDR_OUT_EN
    got_addr.delete();
    got_map.delete();
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Feeds frame[0..n-1] with random gaps; a stray start rides along with input start_at.
  task automatic drive_inputs(input int n, input int gap_pct, input int start_at);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        start    = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = frame[i];
      start    = (i == start_at);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_pct);
    int d0;
    d0 = done_cnt;
    done_with_valid = 1'b1;
    clear_got();
    build_expected();
    pulse_start();
    check_eq({tag, ".busy_run"}, busy, 1);
    drive_inputs(NIN, gap_pct, $urandom_range(100, NIN - 100));
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, ".n_out"}, got_data.size(), NOUT);
    check_eq({tag, ".n_done"}, done_cnt - d0, 1);
    check_eq({tag, ".done_with_valid"}, done_with_valid, 1);
    check_eq({tag, ".busy_after"}, busy, 0);
    for (int i = 0; i < NOUT; i++) begin
      check_eq($sformatf("%s.data[%0d]", tag, i), got_at(i), exp_data[i]);
`ifdef POOL_ADDR_OUT_EN
      check_eq($sformatf("%s.addr[%0d]", tag, i),
               (got_addr.size() > i) ? got_addr[i] : -1, exp_addr[i]);
      check_eq($sformatf("%s.map[%0d]", tag, i),
               (got_map.size() > i) ? got_map[i] : -1, exp_map[i]);
`endif
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".out_valid"}, out_valid, 0);
    check_eq({tag, ".out_data"}, out_data, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".frame_done"}, frame_done, 0);
`ifdef POOL_ADDR_OUT_EN
    check_eq({tag, ".out_address"}, out_address, 0);
    check_eq({tag, ".out_map_sel"}, out_map_sel, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 reset = 1'b1;

    // Input activity in IDLE must be ignored.
    clear_got();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = rand_f();
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle.n_out", got_data.size(), 0);
    check_eq("idle.busy", busy, 0);

    // Ramp on map 0, random elsewhere.
    fill_random();
    for (int i = 0; i < PER_MAP; i++) frame[i] = int2f(i);
    run_frame("ramp", 20);
    check_eq("ramp.first", got_at(0), 32'h41E8_0000);
    check_eq("ramp.last", got_at(HALF * HALF - 1), 32'h4443_C000);
    for (int r = 0; r < HALF; r += 5) begin
      for (int c = 0; c < HALF; c += 4) begin
        check_eq($sformatf("ramp.formula[%0d,%0d]", r, c), got_at(r * HALF + c),
                 int2f(56 * r + 2 * c + 29));
      end
    end

    // Negative window and signed-zero tie window at the start of map 0.
    fill_random();
    frame[0]       = 32'hBF80_0000;
    frame[1]       = 32'hC000_0000;
    frame[IFM]     = 32'hC040_0000;
    frame[IFM + 1] = 32'hC080_0000;
    frame[2]       = 32'h8000_0000;
    frame[3]       = 32'h0000_0000;
    frame[IFM + 2] = 32'h8000_0000;
    frame[IFM + 3] = 32'h8000_0000;
    run_frame("negwin", 30);
    check_eq("negwin.neg", got_at(0), 32'hBF80_0000);
    check_eq("negwin.zero", got_at(1), 32'h8000_0000);

    // Abandon a frame at map 2, row 13 and restart cleanly.
    fill_random();
    pulse_start();
    drive_inputs(2 * PER_MAP + 13 * IFM + 5, 10, -1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check_quiet("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_got();
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst.stale", got_data.size(), 0);
    fill_random();
    run_frame("restart", 15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
